amax10_qsys_burst_read_master: RTL and testbench
================================================

# amax10_qsys_burst_read_master

Avalon-MM read master that fetches a programmed run of 32-bit words from a memory-mapped slave, such as the system's on-chip RAM, and delivers them in order on a valid/ready streaming source. It sits between the Qsys interconnect and streaming consumers (capsense sample processing, display/UART feeders). It keeps reads pipelined and stays credit-limited by an internal FIFO, so it never drops readdatavalid beats.

## Interface
- ADDR_WIDTH, 17: byte-address width of avm_address.
- LEN_WIDTH, 15: width of the word-count field; max run is 2^LEN_WIDTH-1 words.
- FIFO_DEPTH, 8: return-data FIFO depth in words; power of two, at least 2.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ctl_start  in  1  one-cycle start request; sampled only in IDLE.
- ctl_base  in  ADDR_WIDTH  first byte address; bits [1:0] ignored (treated as 0).
- ctl_length  in  LEN_WIDTH  number of words to read.
- ctl_busy  out  1  high from the cycle after an accepted start until done.
- ctl_done  out  1  one-cycle pulse when the run is complete.
- avm_address  out  ADDR_WIDTH  read byte address, word aligned.
- avm_read  out  1  read request.
- avm_byteenable  out  4  constant 4'hF.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  returned data.
- avm_readdatavalid  in  1  returned-data strobe.
- src_data  out  32  stream data (FIFO head).
- src_valid  out  1  stream valid.
- src_ready  in  1  stream ready.

## Operation
- States: IDLE, ISSUE, DRAIN.
  - IDLE: on ctl_start, latch base (aligned) and length, then go to ISSUE. If length is 0, ctl_done pulses next cycle and the state stays IDLE; no read is issued.
  - ISSUE: issues reads until all words have been accepted by the slave, then goes to DRAIN.
  - DRAIN: waits for outstanding=0 and the FIFO to be empty (last word popped), then pulses ctl_done and goes to IDLE.
- Read acceptance: a read is accepted in a cycle where avm_read=1 and avm_waitrequest=0. On acceptance:
  - address advances by 4, modulo 2^ADDR_WIDTH (wraps silently);
  - remaining decrements;
  - outstanding increments.
- Avalon hold rule: while avm_read=1 and avm_waitrequest=1, avm_address and avm_read hold stable.
- Credit rule: the next avm_read is asserted only if remaining_next>0 and outstanding_next+fifo_count_next < FIFO_DEPTH. All terms are post-update values for this edge. This guarantees every readdatavalid beat has a free FIFO slot.
- Return path: avm_readdatavalid writes avm_readdata into the FIFO and decrements outstanding. readdatavalid while outstanding=0 is a slave protocol error; the beat is ignored.
- Stream side: a pop occurs when src_valid=1 and src_ready=1. A FIFO write and a pop in the same cycle are both honoured and the count is unchanged.
- ctl_start outside IDLE is ignored. No soft abort exists; reset_n is the only abort.
- Reset (asynchronous, any state, including mid-run with reads outstanding): go to IDLE and clear the FIFO and all counters. Late readdatavalid beats arriving after reset release are dropped.

## Timing
- Reset values:
  - ctl_busy=0, ctl_done=0;
  - avm_read=0, avm_address=0, avm_byteenable=4'hF;
  - src_valid=0, src_data=0.
- All outputs are registered; avm_byteenable is constant.
- Start sampled at edge 0: ctl_busy=1 and avm_read=1 with avm_address=base from cycle 1.
- Throughput: with waitrequest low and src_ready high, one read is accepted per cycle sustained.
- readdatavalid in cycle k: the word appears on src_data with src_valid=1 in cycle k+1 (show-ahead FIFO).
- Last word popped in cycle p: ctl_done=1 and ctl_busy=0 in cycle p+1, and the block is back in IDLE. A new start is accepted in cycle p+1.

## Test plan
- Basic run: base=0x100, length=4, memory returns data=address with 1-cycle latency, src_ready=1 -> reads at 0x100, 0x104, 0x108, 0x10C on consecutive cycles. src_data sequence is 0x100..0x10C. ctl_done pulses once, 1 cycle after the last pop.
- Zero length: length=0 -> no avm_read; ctl_done=1 in cycle 1; ctl_busy stays 0.
- Backpressure: length=20, src_ready=0 -> at most 8 reads accepted, then avm_read stays 0. Release src_ready -> all 20 words delivered in order with no loss.
- Waitrequest: random waitrequest on length=16 -> address/read stable during every stall; 16 acceptances; data in order.
- Wrap: ADDR_WIDTH=17, base=0x1FFF8, length=4 -> addresses 0x1FFF8, 0x1FFFC, 0x00000, 0x00004.
- Reset mid-run: assert reset_n=0 with 3 reads outstanding -> all outputs at reset values immediately. After release, stray readdatavalid beats produce no src_valid, and a new start runs correctly.

Source files
------------

// File: rtl/amax10_qsys_burst_read_master.sv
// Avalon-MM burst read master: fetches a run of 32-bit words from a slave and
// streams them out in order through a show-ahead return FIFO.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for ctl_start; a zero-length start only pulses ctl_done
// ISSUE | issuing reads, throttled so every returned beat has a FIFO slot
// DRAIN | all reads accepted; waiting for returns and the last pop
module amax10_qsys_burst_read_master #(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN_WIDTH  = 15,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ctl_start,
    input  logic [ADDR_WIDTH-1:0] ctl_base,
    input  logic [LEN_WIDTH-1:0]  ctl_length,
    output logic                  ctl_busy,
    output logic                  ctl_done,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    output logic [3:0]            avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic [31:0]           src_data,
    output logic                  src_valid,
    input  logic                  src_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] remaining;
    logic [CNT_W-1:0]     outstanding;
    logic [CNT_W-1:0]     fifo_count;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [31:0]          mem [FIFO_DEPTH];

    logic                 accept;
    logic                 wr_en;
    logic                 pop;
    logic [LEN_WIDTH-1:0] remaining_next;
    logic [CNT_W-1:0]     outstanding_next;
    logic [CNT_W-1:0]     count_next;
    logic [PTR_W-1:0]     rd_ptr_next;
    logic [CNT_W:0]       credit_sum;
    logic                 credit_ok;

    assign avm_byteenable = 4'hF;

    // Post-edge values of the counters; the credit decision for the next read
    // must use these so that an in-flight beat is never left without a slot.
    always_comb begin
        accept           = avm_read & ~avm_waitrequest;
        wr_en            = avm_readdatavalid & (outstanding != '0);
        pop              = src_valid & src_ready;
        remaining_next   = remaining - LEN_WIDTH'(accept);
        outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(wr_en);
        count_next       = fifo_count + CNT_W'(wr_en) - CNT_W'(pop);
        rd_ptr_next      = rd_ptr + PTR_W'(pop);
        credit_sum       = {1'b0, outstanding_next} + {1'b0, count_next};
        credit_ok        = credit_sum < (CNT_W + 1)'(FIFO_DEPTH);
    end

    // Return-data storage; pointers and count carry the reset, not the array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= avm_readdata;
        end
    end

    // Sequencer, counters and registered outputs. Because the sum of
    // outstanding and FIFO occupancy only grows on acceptance, avm_read and
    // avm_address stay stable through any waitrequest stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            remaining   <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ctl_busy    <= 1'b0;
            ctl_done    <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= '0;
            src_valid   <= 1'b0;
            src_data    <= '0;
        end else begin
            ctl_done    <= 1'b0;
            outstanding <= outstanding_next;
            fifo_count  <= count_next;
            rd_ptr      <= rd_ptr_next;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            src_valid <= (count_next != '0);
            if (count_next != '0) begin
                // When the FIFO is (or becomes) empty apart from this beat,
                // the incoming word is the new head.
                src_data <= (fifo_count == CNT_W'(pop)) ? avm_readdata : mem[rd_ptr_next];
            end
            case (state)
                S_IDLE: begin
                    if (ctl_start) begin
                        if (ctl_length == '0) begin
                            ctl_done <= 1'b1;
                        end else begin
                            state       <= S_ISSUE;
                            ctl_busy    <= 1'b1;
                            avm_read    <= 1'b1;
                            avm_address <= {ctl_base[ADDR_WIDTH-1:2], 2'b00};
                            remaining   <= ctl_length;
                        end
                    end
                end
                S_ISSUE: begin
                    if (accept) begin
                        avm_address <= avm_address + ADDR_WIDTH'(4);
                    end
                    remaining <= remaining_next;
                    avm_read  <= (remaining_next != '0) && credit_ok;
                    if (remaining_next == '0) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (outstanding_next == '0 && count_next == '0) begin
                        state    <= S_IDLE;
                        ctl_busy <= 1'b0;
                        ctl_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_amax10_qsys_burst_read_master.sv
// Directed bench: slave model answering data=address, scoreboard queues for
// expected read addresses and expected stream words.
module tb_amax10_qsys_burst_read_master;
    localparam int AW = 17;
    localparam int LW = 15;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ctl_start;
    logic [AW-1:0] ctl_base;
    logic [LW-1:0] ctl_length;
    logic          ctl_busy;
    logic          ctl_done;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic [3:0]    avm_byteenable;
    logic          avm_waitrequest;
    logic [31:0]   avm_readdata;
    logic          avm_readdatavalid;
    logic [31:0]   src_data;
    logic          src_valid;
    logic          src_ready;

    amax10_qsys_burst_read_master #(
        .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .ctl_start(ctl_start), .ctl_base(ctl_base), .ctl_length(ctl_length),
        .ctl_busy(ctl_busy), .ctl_done(ctl_done),
        .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int passed = 0;
    int failed = 0;

    // slave / sink behaviour knobs: 0 = never, 1 = always (ready) / random (wait), 2 = random (ready) / always (wait)
    int wr_mode = 0;
    int rdy_mode = 1;
    bit hold_resp = 1'b0;
    logic [31:0]   resp_q[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    int accepts = 0;
    int first_acc = 0;
    int last_acc = 0;
    int last_pop = 0;
    int start_cyc = 0;
    bit prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [AW-1:0] base, input int len);
        logic [AW-1:0] a;
        a = {base[AW-1:2], 2'b00};
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back(a);
            exp_data.push_back(32'(a));
            a = a + AW'(4);
        end
        accepts    = 0;
        ctl_base   = base;
        ctl_length = LW'(len);
        ctl_start  = 1'b1;
        start_cyc  = cyc;
        tick();
        ctl_start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int done_cyc);
        int n;
        n = 0;
        done_cyc = -1;
        while (n < budget && ctl_done !== 1'b1) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, ctl_done, 1);
        if (ctl_done === 1'b1) begin
            done_cyc = cyc;
            chk({tag, "_busy_at_done"}, ctl_busy, 0);
            chk({tag, "_done_after_last_pop"}, cyc - last_pop, 1);
            chk({tag, "_words_left"}, exp_data.size(), 0);
            tick();
            chk({tag, "_done_pulse"}, ctl_done, 0);
        end
    endtask

    // Slave and sink: decide waitrequest/ready mid-cycle, score what the closing edge will take.
    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        src_ready         = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall        = 1'b0;
                avm_readdatavalid = 1'b0;
                avm_waitrequest   = 1'b0;
                src_ready         = 1'b0;
            end else begin
                if (!hold_resp && resp_q.size() > 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = resp_q.pop_front();
                end else begin
                    avm_readdatavalid = 1'b0;
                    avm_readdata      = 32'hDEAD_BEEF;
                end
                if (prev_stall) begin
                    chk("hold_read", avm_read, 1);
                    chk("hold_addr", avm_address, prev_addr);
                end
                avm_waitrequest = (wr_mode == 2) ? 1'b1 :
                                  (wr_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
                if (avm_read && !avm_waitrequest) begin
                    chk("read_expected", exp_addr.size() > 0, 1);
                    if (exp_addr.size() > 0) chk("read_addr", avm_address, exp_addr.pop_front());
                    resp_q.push_back(32'(avm_address));
                    if (accepts == 0) first_acc = cyc;
                    last_acc = cyc;
                    accepts++;
                end
                prev_stall = avm_read && avm_waitrequest;
                prev_addr  = avm_address;
                src_ready = (rdy_mode == 1) ? 1'b1 :
                            (rdy_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
                if (src_valid && src_ready) begin
                    chk("beat_expected", exp_data.size() > 0, 1);
                    if (exp_data.size() > 0) chk("src_data", src_data, exp_data.pop_front());
                    last_pop = cyc;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int n;
        ctl_start  = 1'b0;
        ctl_base   = '0;
        ctl_length = '0;
        reset_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", ctl_busy, 0);
        chk("reset_done", ctl_done, 0);
        chk("reset_read", avm_read, 0);
        chk("reset_addr", avm_address, 0);
        chk("reset_be", avm_byteenable, 4'hF);
        chk("reset_valid", src_valid, 0);
        chk("reset_data", src_data, 0);
        reset_n = 1'b1;
        tick();

        // basic run, one read per cycle, done one cycle after last pop
        start_run(17'h100, 4);
        chk("basic_busy_c1", ctl_busy, 1);
        chk("basic_read_c1", avm_read, 1);
        chk("basic_addr_c1", avm_address, 17'h100);
        wait_done("basic", 50, dc);
        chk("basic_done_cycle", dc - start_cyc, 7);
        chk("basic_accepts", accepts, 4);
        chk("basic_first_acc", first_acc - start_cyc, 1);
        chk("basic_acc_span", last_acc - first_acc, 3);

        // zero length
        start_run(17'h40, 0);
        chk("zero_done", ctl_done, 1);
        chk("zero_busy", ctl_busy, 0);
        chk("zero_read", avm_read, 0);
        tick();
        chk("zero_done_pulse", ctl_done, 0);
        chk("zero_busy2", ctl_busy, 0);
        chk("zero_accepts", accepts, 0);

        // backpressure: credit limit caps reads at FIFO depth
        rdy_mode = 0;
        start_run(17'h200, 20);
        repeat (30) tick();
        chk("bp_accepts", accepts, FD);
        chk("bp_read_low", avm_read, 0);
        chk("bp_valid", src_valid, 1);
        chk("bp_busy", ctl_busy, 1);
        rdy_mode = 1;
        wait_done("bp", 300, dc);
        chk("bp_total_accepts", accepts, 20);

        // random waitrequest and random sink ready
        wr_mode  = 1;
        rdy_mode = 2;
        start_run(17'h1000, 16);
        wait_done("wait", 500, dc);
        chk("wait_accepts", accepts, 16);
        chk("wait_addr_left", exp_addr.size(), 0);
        wr_mode  = 0;
        rdy_mode = 1;

        // address wrap, unaligned low bits ignored
        start_run(17'h1FFFB, 4);
        chk("wrap_addr_c1", avm_address, 17'h1FFF8);
        wait_done("wrap", 50, dc);
        chk("wrap_accepts", accepts, 4);

        // reset with three reads outstanding
        hold_resp = 1'b1;
        start_run(17'h300, 8);
        n = 0;
        while (accepts < 3 && n < 20) begin
            tick();
            n++;
        end
        wr_mode = 2;
        chk("rst_accepts", accepts, 3);
        reset_n = 1'b0;
        #1;
        chk("rst_busy", ctl_busy, 0);
        chk("rst_done", ctl_done, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_be", avm_byteenable, 4'hF);
        chk("rst_valid", src_valid, 0);
        chk("rst_data", src_data, 0);
        exp_addr.delete();
        exp_data.delete();
        wr_mode = 0;
        repeat (2) tick();
        reset_n   = 1'b1;
        hold_resp = 1'b0;
        repeat (6) begin
            tick();
            chk("rst_stray_valid", src_valid, 0);
        end
        chk("rst_strays_sent", resp_q.size(), 0);
        chk("rst_idle_busy", ctl_busy, 0);
        start_run(17'h500, 3);
        chk("rerun_addr_c1", avm_address, 17'h500);
        wait_done("rerun", 50, dc);
        chk("rerun_accepts", accepts, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
